udp_deadlock_report_ctrl: RTL and testbench

//  Supervises the per-region HLS deadlock monitor flags of the UDP stack dataflow hierarchy.

---
 rtl/udp_deadlock_report_ctrl_if.sv | 33 +++
 rtl/udp_deadlock_report_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_udp_deadlock_report_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_deadlock_report_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : udp_deadlock_report_ctrl_if
//  Description : Valid/ready report channel carrying the index of a deadlocked
//                dataflow region and the cycle timestamp of its detection.
//  Revision    : 1.0  initial release
// ============================================================================
interface udp_deadlock_report_ctrl_if #(
    parameter int IDX_W = 2,
    parameter int TS_W  = 32
);
    logic              rpt_valid;
    logic              rpt_ready;
    logic [IDX_W-1:0]  rpt_idx;
    logic [TS_W-1:0]   rpt_timestamp;

    // Producer side: the report controller
    modport master (
        output rpt_valid,
        output rpt_idx,
        output rpt_timestamp,
        input  rpt_ready
    );

    // Consumer side: debug / CSR path
    modport slave (
        input  rpt_valid,
        input  rpt_idx,
        input  rpt_timestamp,
        output rpt_ready
    );
endinterface
`default_nettype wire

// File: rtl/udp_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : udp_deadlock_report_ctrl
//  Description : Supervises the per-region HLS deadlock monitor flags of the
//                UDP dataflow hierarchy. Each flag must stay high for
//                HOLD_CYCLES consecutive cycles before it is considered a
//                deadlock; deadlocked regions are then reported once each,
//                round-robin, over a single valid/ready channel together with
//                a free-running cycle timestamp.
//  Revision    : 1.0  initial release
// ============================================================================
module udp_deadlock_report_ctrl #(
    parameter int NUM_MON     = 4,
    parameter int HOLD_CYCLES = 256,
    parameter int TS_W        = 32,
    parameter int IDX_W       = 2
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    input  wire logic                 enable_i,
    input  wire logic [NUM_MON-1:0]   mon_block_i,
    input  wire logic                 clear_sticky_i,
    udp_deadlock_report_ctrl_if.master rpt_if,
    output      logic [15:0]          rpt_count_o,
    output      logic                 any_deadlock_o
);

    // Persistence counters only need to reach HOLD_CYCLES, then saturate.
    localparam int              CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_HOLD = CNT_W'(HOLD_CYCLES);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]                      state_q, state_d;
    logic [TS_W-1:0]                 ts_q, ts_d;
    logic [NUM_MON-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MON-1:0]              reported_q, reported_d;
    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                rpt_idx_q, rpt_idx_d;
    logic [TS_W-1:0]                 rpt_ts_q, rpt_ts_d;
    logic [15:0]                     rpt_count_q, rpt_count_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                            accept;
    logic [NUM_MON-1:0]              persistent;
    logic [NUM_MON-1:0]              held_onehot;
    logic [NUM_MON-1:0]              accept_onehot;
    logic [NUM_MON-1:0]              pending;
    logic                            pick_found;
    logic [IDX_W-1:0]                pick_idx;

    assign accept = (state_q == c_ST_SEND) && rpt_if.rpt_ready;

    // Per-region persistence filter: a flag only counts once it has been
    // continuously high for HOLD_CYCLES cycles while supervision is enabled.
    always_comb begin
        cnt_d      = '0;
        persistent = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            if (!enable_i || !mon_block_i[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == c_HOLD) begin
                cnt_d[i] = c_HOLD;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            persistent[i] = (cnt_q[i] == c_HOLD);
        end
    end

    // One-hot of the region currently being offered, and of the one accepted.
    always_comb begin
        held_onehot = '0;
        if (state_q == c_ST_SEND) begin
            held_onehot[rpt_idx_q] = 1'b1;
        end
        accept_onehot = accept ? held_onehot : '0;
    end

    // Sticky "already reported" bits: re-armed when the flag drops, cleared
    // wholesale by clear_sticky (which wins over a same-cycle accept).
    assign reported_d = (reported_q | accept_onehot)
                        & mon_block_i
                        & ~{NUM_MON{clear_sticky_i}};

    assign pending = persistent & ~reported_q & ~held_onehot;

    // Round-robin pick: first pending region at or after rr_ptr, wrapping.
    // The loop runs from the farthest offset down so the nearest one wins.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] j_idx;
        j          = 0;
        j_idx      = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_MON - 1; k >= 0; k--) begin
            j     = (int'(rr_ptr_q) + k) % NUM_MON;
            j_idx = IDX_W'(j);
            if (pending[j_idx]) begin
                pick_found = 1'b1;
                pick_idx   = j_idx;
            end
        end
    end

    // Report scheduler: latch a region in IDLE, hold it stable in SEND until
    // the consumer takes it. A report is never withdrawn once offered.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rpt_idx_d   = rpt_idx_q;
        rpt_ts_d    = rpt_ts_q;
        rpt_count_d = rpt_count_q;
        ts_d        = ts_q + 1'b1;
        case (state_q)
            c_ST_IDLE: begin
                if (pick_found) begin
                    state_d   = c_ST_SEND;
                    rpt_idx_d = pick_idx;
                    rpt_ts_d  = ts_q;
                end
            end
            c_ST_SEND: begin
                if (accept) begin
                    state_d = c_ST_IDLE;
                    if (rpt_idx_q == IDX_W'(NUM_MON - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = rpt_idx_q + 1'b1;
                    end
                    if (rpt_count_q != 16'hFFFF) begin
                        rpt_count_d = rpt_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Register update with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= c_ST_IDLE;
            ts_q        <= '0;
            cnt_q       <= '0;
            reported_q  <= '0;
            rr_ptr_q    <= '0;
            rpt_idx_q   <= '0;
            rpt_ts_q    <= '0;
            rpt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            cnt_q       <= cnt_d;
            reported_q  <= reported_d;
            rr_ptr_q    <= rr_ptr_d;
            rpt_idx_q   <= rpt_idx_d;
            rpt_ts_q    <= rpt_ts_d;
            rpt_count_q <= rpt_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rpt_if.rpt_valid     = (state_q == c_ST_SEND);
    assign rpt_if.rpt_idx       = rpt_idx_q;
    assign rpt_if.rpt_timestamp = rpt_ts_q;
    assign rpt_count_o          = rpt_count_q;
    // Raw view of persistence, independent of what has been reported.
    assign any_deadlock_o       = |persistent;

endmodule
`default_nettype wire

// File: tb/tb_udp_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_deadlock_report_ctrl
//  Description : Self-checking bench for udp_deadlock_report_ctrl with
//                NUM_MON=4, HOLD_CYCLES=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_udp_deadlock_report_ctrl;

    localparam int NUM_MON = 4;
    localparam int HOLD    = 4;
    localparam int TS_W    = 32;
    localparam int IDX_W   = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic                enable_i;
    logic [NUM_MON-1:0]  mon_block_i;
    logic                clear_sticky_i;
    logic [15:0]         rpt_count_o;
    logic                any_deadlock_o;

    udp_deadlock_report_ctrl_if #(.IDX_W(IDX_W), .TS_W(TS_W)) rpt_bus ();

    udp_deadlock_report_ctrl #(
        .NUM_MON     (NUM_MON),
        .HOLD_CYCLES (HOLD),
        .TS_W        (TS_W),
        .IDX_W       (IDX_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable_i       (enable_i),
        .mon_block_i    (mon_block_i),
        .clear_sticky_i (clear_sticky_i),
        .rpt_if         (rpt_bus),
        .rpt_count_o    (rpt_count_o),
        .any_deadlock_o (any_deadlock_o)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the rules stated as plain per-cycle arithmetic.
    // ------------------------------------------------------------------------
    int          m_cnt [NUM_MON];
    bit          m_rep [NUM_MON];
    bit          m_busy;
    int          m_idx, m_rr, m_count;
    logic [31:0] m_ts, m_stamp;

    function automatic bit m_any();
        bit a = 0;
        for (int i = 0; i < NUM_MON; i++) if (m_cnt[i] == HOLD) a = 1;
        return a;
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // then advance the DUT by one clock.
    task automatic step();
        bit acc;
        bit pend [NUM_MON];
        bit found;
        int j;
        if (reset) begin
            m_ts = 0; m_busy = 0; m_idx = 0; m_stamp = 0; m_rr = 0; m_count = 0;
            for (int i = 0; i < NUM_MON; i++) begin m_cnt[i] = 0; m_rep[i] = 0; end
        end else begin
            acc = m_busy && rpt_bus.rpt_ready;
            for (int i = 0; i < NUM_MON; i++) pend[i] = (m_cnt[i] == HOLD) && !m_rep[i];
            for (int i = 0; i < NUM_MON; i++) begin
                m_rep[i] = (m_rep[i] || (acc && m_idx == i)) && mon_block_i[i] && !clear_sticky_i;
                if (enable_i && mon_block_i[i]) m_cnt[i] = (m_cnt[i] + 1 > HOLD) ? HOLD : m_cnt[i] + 1;
                else                            m_cnt[i] = 0;
            end
            if (m_busy) begin
                if (acc) begin
                    m_busy  = 0;
                    m_rr    = (m_idx + 1) % NUM_MON;
                    m_count = (m_count == 65535) ? 65535 : m_count + 1;
                end
            end else begin
                found = 0;
                for (int k = 0; k < NUM_MON; k++) begin
                    j = (m_rr + k) % NUM_MON;
                    if (!found && pend[j]) begin
                        found = 1; m_busy = 1; m_idx = j; m_stamp = m_ts;
                    end
                end
            end
            m_ts = m_ts + 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_model();
        chk("model_valid", 64'(rpt_bus.rpt_valid), 64'(m_busy));
        if (m_busy) begin
            chk("model_idx", 64'(rpt_bus.rpt_idx), 64'(m_idx));
            chk("model_ts",  64'(rpt_bus.rpt_timestamp), 64'(m_stamp));
        end
        chk("model_count", 64'(rpt_count_o), 64'(m_count));
        chk("model_any",   64'(any_deadlock_o), 64'(m_any()));
    endtask

    task automatic do_reset();
        reset = 1; enable_i = 1; mon_block_i = '0; clear_sticky_i = 0; rpt_bus.rpt_ready = 0;
        step();
        step();
        reset = 0;
    endtask

    typedef struct {
        logic [3:0]  mon;
        logic        ready;
        logic        exp_valid;
        logic [1:0]  exp_idx;
        logic [31:0] exp_ts;
        logic [15:0] exp_cnt;
        logic        exp_any;
    } vec_t;

    vec_t tbl [15];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          first_v;
        int          accepts;
        logic [1:0]  s_idx;
        logic [31:0] s_ts;
        bit          seen_v, seen_a, stable, found;

        // All four flags raised together; row r is cycle r after reset (ts = r).
        tbl[0]  = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd0, 1'b0};
        tbl[1]  = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd0, 1'b0};
        tbl[2]  = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd0, 1'b0};
        tbl[3]  = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd0, 1'b0};
        tbl[4]  = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd0, 1'b1};
        tbl[5]  = '{4'hF, 1'b1, 1'b1, 2'd0, 32'd4,  16'd0, 1'b1};
        tbl[6]  = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd1, 1'b1};
        tbl[7]  = '{4'hF, 1'b1, 1'b1, 2'd1, 32'd6,  16'd1, 1'b1};
        tbl[8]  = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd2, 1'b1};
        tbl[9]  = '{4'hF, 1'b1, 1'b1, 2'd2, 32'd8,  16'd2, 1'b1};
        tbl[10] = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd3, 1'b1};
        tbl[11] = '{4'hF, 1'b1, 1'b1, 2'd3, 32'd10, 16'd3, 1'b1};
        tbl[12] = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd4, 1'b1};
        tbl[13] = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd4, 1'b1};
        tbl[14] = '{4'hF, 1'b1, 1'b0, 2'd0, 32'd0,  16'd4, 1'b1};

        reset = 1; enable_i = 1; mon_block_i = '0; clear_sticky_i = 0; rpt_bus.rpt_ready = 0;
        #1;

        // ---- Reset state and single persistent flag ---------------------------
        do_reset();
        chk("rst_valid", 64'(rpt_bus.rpt_valid), 64'd0);
        chk("rst_idx",   64'(rpt_bus.rpt_idx), 64'd0);
        chk("rst_ts",    64'(rpt_bus.rpt_timestamp), 64'd0);
        chk("rst_count", 64'(rpt_count_o), 64'd0);
        chk("rst_any",   64'(any_deadlock_o), 64'd0);
        rpt_bus.rpt_ready = 1;
        step();                             // now cycle ts=1
        mon_block_i = 4'b0100;
        first_v = -1; accepts = 0; s_idx = '0; s_ts = '0;
        for (int c = 1; c < 40; c++) begin
            if (rpt_bus.rpt_valid && first_v < 0) begin
                first_v = c; s_idx = rpt_bus.rpt_idx; s_ts = rpt_bus.rpt_timestamp;
            end
            if (rpt_bus.rpt_valid && rpt_bus.rpt_ready) accepts++;
            step();
        end
        chk("t1_first_valid_cycle", 64'(first_v), 64'd6);
        chk("t1_idx",     64'(s_idx), 64'd2);
        chk("t1_ts",      64'(s_ts), 64'd5);
        chk("t1_accepts", 64'(accepts), 64'd1);
        chk("t1_count",   64'(rpt_count_o), 64'd1);

        // ---- Short pulses never qualify --------------------------------------
        do_reset();
        rpt_bus.rpt_ready = 1;
        seen_v = 0; seen_a = 0;
        for (int c = 0; c < 48; c++) begin
            mon_block_i = ((c % 4) < 3) ? 4'b0001 : 4'b0000;
            if (rpt_bus.rpt_valid) seen_v = 1;
            if (any_deadlock_o)    seen_a = 1;
            step();
        end
        chk("t2_never_valid", 64'(seen_v), 64'd0);
        chk("t2_never_any",   64'(seen_a), 64'd0);

        // ---- Table: all flags together, round-robin --------------------------
        do_reset();
        for (int r = 0; r < 15; r++) begin
            mon_block_i       = tbl[r].mon;
            rpt_bus.rpt_ready = tbl[r].ready;
            chk($sformatf("t3_valid[%0d]", r), 64'(rpt_bus.rpt_valid), 64'(tbl[r].exp_valid));
            if (tbl[r].exp_valid) begin
                chk($sformatf("t3_idx[%0d]", r), 64'(rpt_bus.rpt_idx), 64'(tbl[r].exp_idx));
                chk($sformatf("t3_ts[%0d]", r),  64'(rpt_bus.rpt_timestamp), 64'(tbl[r].exp_ts));
            end
            chk($sformatf("t3_count[%0d]", r), 64'(rpt_count_o), 64'(tbl[r].exp_cnt));
            chk($sformatf("t3_any[%0d]", r),   64'(any_deadlock_o), 64'(tbl[r].exp_any));
            step();
        end

        // ---- Back-pressure: report held stable -------------------------------
        do_reset();
        mon_block_i = 4'b1000;
        for (int c = 0; c < 20 && !rpt_bus.rpt_valid; c++) step();
        chk("t4_valid_rises", 64'(rpt_bus.rpt_valid), 64'd1);
        s_idx = rpt_bus.rpt_idx; s_ts = rpt_bus.rpt_timestamp;
        chk("t4_idx", 64'(s_idx), 64'd3);
        stable = 1;
        for (int c = 0; c < 10; c++) begin
            if (!rpt_bus.rpt_valid || rpt_bus.rpt_idx != s_idx || rpt_bus.rpt_timestamp != s_ts) stable = 0;
            step();
        end
        chk("t4_stable", 64'(stable), 64'd1);
        rpt_bus.rpt_ready = 1;
        step();
        chk("t4_valid_drops", 64'(rpt_bus.rpt_valid), 64'd0);
        chk("t4_count",       64'(rpt_count_o), 64'd1);
        seen_v = 0;
        for (int c = 0; c < 10; c++) begin
            if (rpt_bus.rpt_valid) seen_v = 1;
            step();
        end
        chk("t4_no_repeat", 64'(seen_v), 64'd0);

        // ---- Reset while a report is being offered ---------------------------
        rpt_bus.rpt_ready = 0;
        clear_sticky_i = 1;
        step();
        clear_sticky_i = 0;
        for (int c = 0; c < 10 && !rpt_bus.rpt_valid; c++) step();
        chk("t6_in_send", 64'(rpt_bus.rpt_valid), 64'd1);
        reset = 1;
        step();
        reset = 0;
        chk("t6_valid", 64'(rpt_bus.rpt_valid), 64'd0);
        chk("t6_count", 64'(rpt_count_o), 64'd0);
        chk("t6_any",   64'(any_deadlock_o), 64'd0);
        chk("t6_ts_out", 64'(rpt_bus.rpt_timestamp), 64'd0);
        rpt_bus.rpt_ready = 1;
        for (int c = 0; c < 10 && !rpt_bus.rpt_valid; c++) step();
        chk("t6_idx",         64'(rpt_bus.rpt_idx), 64'd3);
        chk("t6_ts_restarts", 64'(rpt_bus.rpt_timestamp), 64'd4);
        step();

        // ---- Re-arm by flag drop and by clear_sticky -------------------------
        do_reset();
        rpt_bus.rpt_ready = 1;
        mon_block_i = 4'b0010;
        for (int c = 0; c < 20 && !rpt_bus.rpt_valid; c++) step();
        chk("t5_first_idx", 64'(rpt_bus.rpt_idx), 64'd1);
        for (int c = 0; c < 3; c++) step();
        mon_block_i = 4'b0000;
        step();
        mon_block_i = 4'b0010;
        first_v = -1;
        for (int k = 0; k < 12; k++) begin
            if (rpt_bus.rpt_valid && first_v < 0) begin
                first_v = k; s_idx = rpt_bus.rpt_idx;
            end
            step();
        end
        chk("t5_rearm_delay", 64'(first_v), 64'd5);
        chk("t5_rearm_idx",   64'(s_idx), 64'd1);
        clear_sticky_i = 1;
        step();
        clear_sticky_i = 0;
        chk("t5_clr_not_yet", 64'(rpt_bus.rpt_valid), 64'd0);
        step();
        found = rpt_bus.rpt_valid;
        chk("t5_clr_valid", 64'(found), 64'd1);
        chk("t5_clr_idx",   64'(rpt_bus.rpt_idx), 64'd1);
        step();
        chk("t5_count", 64'(rpt_count_o), 64'd3);

        // ---- Randomized run against the model --------------------------------
        do_reset();
        mon_block_i = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 12)
                mon_block_i[$urandom_range(0, NUM_MON - 1)] ^= 1'b1;
            enable_i          = ($urandom_range(0, 99) >= 2);
            rpt_bus.rpt_ready = ($urandom_range(0, 99) < 60);
            clear_sticky_i    = ($urandom_range(0, 99) < 3);
            reset             = ($urandom_range(0, 999) < 3);
            check_model();
            step();
        end
        reset = 0;
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
